// File: rtl/sdram_bist_pkg.sv
// sdram_bist_pkg
//   Shared types and helpers for the SDRAM BIST controller.
//   - state_t       : controller FSM states
//   - DATA_W/ADDR_W : master buffer width and base/length width
//   - LFSR_TAPS     : feedback mask for taps 64,63,61,60 (bits 63,62,60,59)
//   - pattern_word  : counter-mode pattern {seed[63:32]^idx, ~idx}
//   - lfsr_next     : one Fibonacci LFSR step (only with SDRAM_BIST_LFSR_EN)
package sdram_bist_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;

    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_GO,
        ST_WR_FILL,
        ST_WR_WAIT,
        ST_RD_GO,
        ST_RD_DRAIN,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] pattern_word(input logic [31:0]       idx,
                                                       input logic [DATA_W-1:0] seed);
        return {seed[63:32] ^ idx, ~idx};
    endfunction

`ifdef SDRAM_BIST_LFSR_EN
    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], ^(s & LFSR_TAPS)};
    endfunction
`endif

endpackage

// File: rtl/sdram_bist_ctrl_if.sv
// sdram_bist_ctrl_if
//   Control/user conduits of the qsys SDRAM write master and read master.
//   master : BIST controller side (drives go/base/length/push/pop)
//   slave  : qsys master side (drives done/full/read data/available)
interface sdram_bist_ctrl_if;
    import sdram_bist_pkg::*;

    logic              wr_fixed_location;
    logic [ADDR_W-1:0] wr_base;
    logic [ADDR_W-1:0] wr_length;
    logic              wr_go;
    logic              wr_done;
    logic              wr_write_buffer;
    logic [DATA_W-1:0] wr_buffer_input_data;
    logic              wr_buffer_full;

    logic              rd_fixed_location;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_length;
    logic              rd_go;
    logic              rd_done;
    logic              rd_early_done;
    logic              rd_read_buffer;
    logic [DATA_W-1:0] rd_buffer_output_data;
    logic              rd_data_available;

    modport master (
        output wr_fixed_location, wr_base, wr_length, wr_go, wr_write_buffer,
               wr_buffer_input_data,
        input  wr_done, wr_buffer_full,
        output rd_fixed_location, rd_base, rd_length, rd_go, rd_read_buffer,
        input  rd_done, rd_early_done, rd_buffer_output_data, rd_data_available
    );

    modport slave (
        input  wr_fixed_location, wr_base, wr_length, wr_go, wr_write_buffer,
               wr_buffer_input_data,
        output wr_done, wr_buffer_full,
        input  rd_fixed_location, rd_base, rd_length, rd_go, rd_read_buffer,
        output rd_done, rd_early_done, rd_buffer_output_data, rd_data_available
    );

endinterface

// File: rtl/sdram_bist_patgen.sv
// sdram_bist_patgen
//   Pattern generator for one side (write or read) of the BIST.
//   Macro SDRAM_BIST_LFSR_EN selects a 64-bit Fibonacci LFSR seeded with SEED
//   (zero seed replaced by 1); otherwise a word counter feeding pattern_word().
//   clk_i     : clock
//   rst_n_i   : synchronous active-low reset
//   load_i    : restart the sequence at word 0
//   advance_i : step to the next word (word consumed this cycle)
//   word_o    : current pattern word
module sdram_bist_patgen
    import sdram_bist_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              advance_i,
    output logic [DATA_W-1:0] word_o
);

`ifdef SDRAM_BIST_LFSR_EN
    // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
    localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;

    logic [63:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign word_o = lfsr_q;
`else
    logic [31:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = 32'd0;
        end else if (advance_i) begin
            idx_d = idx_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idx_q <= 32'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign word_o = pattern_word(idx_q, SEED);
`endif

endmodule

// File: rtl/sdram_bist_ctrl.sv
// sdram_bist_ctrl
//   Fills an SDRAM region with a deterministic pattern via the qsys write
//   master, reads it back via the read master and compares every word.
//   Macro SDRAM_BIST_LFSR_EN switches the pattern to a 64-bit LFSR.
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   start                  : one-cycle request, honoured only when idle
//   busy, done             : test in progress / one-cycle completion pulse
//   pass, fail             : sticky result of the last test
//   err_count              : mismatching words (saturating)
//   first_err_addr         : byte address of the first mismatch
//   bus                    : write/read master control and user conduits
//
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_WR_GO    | one-cycle wr_go pulse
//   ST_WR_FILL  | pushing NWORDS pattern words into the write FIFO
//   ST_WR_WAIT  | waiting for the write master to finish
//   ST_RD_GO    | one-cycle rd_go pulse
//   ST_RD_DRAIN | popping and comparing NWORDS words
//   ST_RD_WAIT  | waiting for the read master to finish
//   ST_DONE     | one-cycle done pulse, result visible
module sdram_bist_ctrl
    import sdram_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned       LENGTH_BYTES = 4096,
    parameter logic [DATA_W-1:0] SEED         = 64'h0123_4567_89AB_CDEF
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [15:0]        err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    sdram_bist_ctrl_if.master  bus
);

    if (LENGTH_BYTES == 0 || (LENGTH_BYTES % 8) != 0) begin : g_len_chk
        $error("sdram_bist_ctrl: LENGTH_BYTES must be a nonzero multiple of 8");
    end
    if (BASE_ADDR[2:0] != 3'b000) begin : g_base_chk
        $error("sdram_bist_ctrl: BASE_ADDR must be 8-byte aligned");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH_BYTES / 8 - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [ADDR_W-1:0] ridx_q, ridx_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic              push, pop, mismatch, wr_load, rd_load;
    logic [DATA_W-1:0] wr_word, rd_word;
    logic              unused_early_done;

    always_comb begin
        state_d  = state_q;
        widx_d   = widx_q;
        ridx_d   = ridx_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        push     = 1'b0;
        pop      = 1'b0;
        mismatch = 1'b0;
        wr_load  = 1'b0;
        rd_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_GO;
                    err_d   = 16'd0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ST_WR_GO: begin
                wr_load = 1'b1;
                widx_d  = '0;
                state_d = ST_WR_FILL;
            end
            ST_WR_FILL: begin
                push = !bus.wr_buffer_full;
                if (push) begin
                    widx_d = widx_q + ADDR_W'(1);
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_WR_WAIT;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (bus.wr_done) begin
                    state_d = ST_RD_GO;
                end
            end
            ST_RD_GO: begin
                rd_load = 1'b1;
                ridx_d  = '0;
                state_d = ST_RD_DRAIN;
            end
            ST_RD_DRAIN: begin
                // Show-ahead FIFO: the head word is valid in the pop cycle.
                pop = bus.rd_data_available;
                if (pop) begin
                    mismatch = (bus.rd_buffer_output_data != rd_word);
                    ridx_d   = ridx_q + ADDR_W'(1);
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        // err_count saturates, so zero only before the first miss.
                        if (err_q == 16'd0) begin
                            ferr_d = BASE_ADDR + {ridx_q[ADDR_W-4:0], 3'b000};
                        end
                    end
                    if (ridx_q == LAST_IDX) begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (bus.rd_done) begin
                    state_d = ST_DONE;
                    pass_d  = (err_q == 16'd0);
                    fail_d  = (err_q != 16'd0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            widx_q  <= '0;
            ridx_q  <= '0;
            err_q   <= 16'd0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    sdram_bist_patgen #(.SEED(SEED)) u_patgen_wr (
        .clk_i     (clk_clk),
        .rst_n_i   (reset_reset_n),
        .load_i    (wr_load),
        .advance_i (push),
        .word_o    (wr_word)
    );

    sdram_bist_patgen #(.SEED(SEED)) u_patgen_rd (
        .clk_i     (clk_clk),
        .rst_n_i   (reset_reset_n),
        .load_i    (rd_load),
        .advance_i (pop),
        .word_o    (rd_word)
    );

    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

    assign bus.wr_fixed_location    = 1'b0;
    assign bus.wr_base              = BASE_ADDR;
    assign bus.wr_length            = ADDR_W'(LENGTH_BYTES);
    assign bus.wr_go                = (state_q == ST_WR_GO);
    assign bus.wr_write_buffer      = push;
    assign bus.wr_buffer_input_data = wr_word;

    assign bus.rd_fixed_location    = 1'b0;
    assign bus.rd_base              = BASE_ADDR;
    assign bus.rd_length            = ADDR_W'(LENGTH_BYTES);
    assign bus.rd_go                = (state_q == ST_RD_GO);
    assign bus.rd_read_buffer       = pop;

    // Early-done is reserved on this conduit and intentionally unused.
    assign unused_early_done = bus.rd_early_done;

endmodule

// File: tb/tb_sdram_bist_ctrl.sv
module tb_sdram_bist_ctrl;
    import sdram_bist_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          LEN  = 64;
    localparam int          NW   = LEN / 8;
    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CORR = 64'h0000_0000_0000_0100;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, fail;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    sdram_bist_ctrl_if bus ();

    sdram_bist_ctrl #(.BASE_ADDR(BASE), .LENGTH_BYTES(LEN), .SEED(SEED)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .bus            (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- loopback SDRAM + FIFO model ----------------
    logic [63:0] mem [NW];
    logic [63:0] exp_word [NW];
    int  cyc = 0, wcount = 0, rcount = 0, wr_tail = 0, rd_tail = 0, stall_cnt = 0;
    bit  rd_active = 0;
    int  n_wr_go = 0, n_rd_go = 0, n_done = 0, pushes = 0, pops = 0;
    int  viol_full = 0, viol_avail = 0, pop_cyc = 0, done_cyc = 0;
    int  clr_gen = 0, clr_seen = 0;
    int  k_stall_after = -1, k_stall_len = 0;
    bit  k_toggle = 0, k_rand = 0;
    logic [7:0] k_corrupt = 8'h00;

    initial begin
        bus.wr_done = 0; bus.wr_buffer_full = 0; bus.rd_done = 0; bus.rd_early_done = 0;
        bus.rd_data_available = 0; bus.rd_buffer_output_data = '0;
        forever begin
            @(negedge clk_clk);
            cyc++;
            if (clr_gen != clr_seen) begin
                clr_seen = clr_gen;
                wcount = 0; rcount = 0; wr_tail = 0; rd_tail = 0; stall_cnt = 0; rd_active = 0;
                n_wr_go = 0; n_rd_go = 0; n_done = 0; pushes = 0; pops = 0;
                viol_full = 0; viol_avail = 0; pop_cyc = 0; done_cyc = 0;
                for (int i = 0; i < NW; i++) mem[i] = '0;
            end
            if (stall_cnt > 0) begin
                bus.wr_buffer_full = 1'b1;
                stall_cnt--;
            end else begin
                bus.wr_buffer_full = k_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (wcount >= NW && wr_tail < 3) wr_tail++;
            bus.wr_done = (wr_tail >= 3);
            if (rd_active && rcount >= NW && rd_tail < 3) rd_tail++;
            bus.rd_done = (rd_tail >= 3);
            if (rd_active && rcount < NW) begin
                bus.rd_data_available = k_toggle ? cyc[0] : (k_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
                bus.rd_buffer_output_data = mem[rcount] ^ (k_corrupt[rcount] ? CORR : 64'd0);
            end else begin
                bus.rd_data_available = 1'b0;
                bus.rd_buffer_output_data = '0;
            end
            #1;
            if (bus.wr_go) begin n_wr_go++; wcount = 0; wr_tail = 0; end
            if (bus.wr_write_buffer) begin
                if (bus.wr_buffer_full) viol_full++;
                if (wcount < NW) mem[wcount] = bus.wr_buffer_input_data;
                wcount++; pushes++;
                if (wcount == k_stall_after) stall_cnt = k_stall_len;
            end
            if (bus.rd_go) begin n_rd_go++; rd_active = 1; rcount = 0; rd_tail = 0; end
            if (bus.rd_read_buffer) begin
                if (!bus.rd_data_available) viol_avail++;
                rcount++; pops++; pop_cyc = cyc;
            end
            if (done) begin n_done++; done_cyc = cyc; end
        end
    end

    // ---------------- reference expectations ----------------
    function automatic int ref_err(input logic [7:0] cm);
        int c = 0;
        for (int i = 0; i < NW; i++) if (cm[i]) c++;
        return c;
    endfunction

    function automatic logic [31:0] ref_first(input logic [7:0] cm);
        logic [31:0] a = 32'h0;
        bit got = 0;
        for (int i = 0; i < NW; i++) begin
            if (cm[i] && !got) begin a = BASE + 32'(8 * i); got = 1; end
        end
        return a;
    endfunction

    task automatic run_test(input string nm, input int sa, input int sl, input bit tg,
                            input bit rn, input bit poke, input logic [7:0] cm,
                            input bit ep, input int ee, input logic [31:0] ef);
        bit found = 0;
        bit poked = 0;
        int mism = 0;
        k_stall_after = sa; k_stall_len = sl; k_toggle = tg; k_rand = rn; k_corrupt = cm;
        clr_gen++;
        @(posedge clk_clk); #1;
        start = 1'b1;
        @(posedge clk_clk); #1;
        start = 1'b0;
        chk({nm, "/wr_go_latency"}, bus.wr_go, 1);
        chk({nm, "/busy_after_start"}, busy, 1);
        for (int i = 0; i < 3000 && !found; i++) begin
            if (poke && !poked && pops >= 2 && pops < NW - 1) begin
                start = 1'b1; poked = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk_clk); #1;
            if (done) found = 1;
        end
        start = 1'b0;
        chk({nm, "/done_seen"}, found, 1);
        chk({nm, "/pass"}, pass, ep);
        chk({nm, "/fail"}, fail, !ep);
        chk({nm, "/err_count"}, err_count, 64'(ee));
        chk({nm, "/first_err_addr"}, first_err_addr, ef);
        chk({nm, "/busy_in_done"}, busy, 0);
        @(posedge clk_clk); #1;
        chk({nm, "/done_one_cycle"}, done, 0);
        chk({nm, "/pass_sticky"}, pass, ep);
        repeat (6) @(posedge clk_clk);
        #1;
        for (int i = 0; i < NW; i++) if (mem[i] !== exp_word[i]) mism++;
        chk({nm, "/written_words"}, mism, 0);
        chk({nm, "/pushes"}, pushes, NW);
        chk({nm, "/pops"}, pops, NW);
        chk({nm, "/wr_go_count"}, n_wr_go, 1);
        chk({nm, "/rd_go_count"}, n_rd_go, 1);
        chk({nm, "/done_count"}, n_done, 1);
        chk({nm, "/push_while_full"}, viol_full, 0);
        chk({nm, "/pop_while_empty"}, viol_avail, 0);
        chk({nm, "/pop_to_done"}, (done_cyc - pop_cyc >= 2), 1);
        if (poke) chk({nm, "/poke_in_drain"}, poked, 1);
    endtask

    typedef struct {
        int         sa;
        int         sl;
        bit         tg;
        bit         poke;
        logic [7:0] cm;
        bit         ep;
        int         ee;
        logic [31:0] ef;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] s;
        logic [7:0]  cm;
        // stall_after, stall_len, toggle, poke, corrupt, exp_pass, exp_err, exp_first
        vecs[0] = '{-1, 0, 1'b0, 1'b0, 8'h00, 1'b1, 0, BASE};
        vecs[1] = '{ 3, 5, 1'b0, 1'b0, 8'h00, 1'b1, 0, BASE};
        vecs[2] = '{-1, 0, 1'b0, 1'b0, 8'h08, 1'b0, 1, BASE + 32'd24};
        vecs[3] = '{-1, 0, 1'b1, 1'b1, 8'h00, 1'b1, 0, BASE};
        vecs[4] = '{ 2, 3, 1'b1, 1'b0, 8'h81, 1'b0, 2, BASE};
        vecs[5] = '{-1, 0, 1'b0, 1'b0, 8'hF0, 1'b0, 4, BASE + 32'd32};

`ifdef SDRAM_BIST_LFSR_EN
        s = (SEED == 64'd0) ? 64'd1 : SEED;
        for (int i = 0; i < NW; i++) begin
            exp_word[i] = s;
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
`else
        s = SEED;
        for (int i = 0; i < NW; i++) exp_word[i] = {s[63:32] ^ 32'(i), ~32'(i)};
`endif

        // Reset state
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/pass", pass, 0);
        chk("rst/fail", fail, 0);
        chk("rst/err_count", err_count, 0);
        chk("rst/first_err_addr", first_err_addr, 0);
        chk("rst/wr_go", bus.wr_go, 0);
        chk("rst/rd_go", bus.rd_go, 0);
        chk("rst/wr_write_buffer", bus.wr_write_buffer, 0);
        chk("rst/rd_read_buffer", bus.rd_read_buffer, 0);
        chk("const/wr_base", bus.wr_base, BASE);
        chk("const/wr_length", bus.wr_length, LEN);
        chk("const/rd_base", bus.rd_base, BASE);
        chk("const/rd_length", bus.rd_length, LEN);
        chk("const/fixed_location", {bus.wr_fixed_location, bus.rd_fixed_location}, 0);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;

        for (int v = 0; v < 6; v++) begin
            run_test($sformatf("vec%0d", v), vecs[v].sa, vecs[v].sl, vecs[v].tg, 1'b0,
                     vecs[v].poke, vecs[v].cm, vecs[v].ep, vecs[v].ee, vecs[v].ef);
        end

        // Reset asserted for one cycle in the middle of the fill
        begin
            bit reached = 0;
            k_stall_after = -1; k_stall_len = 0; k_toggle = 0; k_rand = 0; k_corrupt = 8'h00;
            clr_gen++;
            @(posedge clk_clk); #1;
            start = 1'b1;
            @(posedge clk_clk); #1;
            start = 1'b0;
            for (int i = 0; i < 200 && !reached; i++) begin
                @(posedge clk_clk); #1;
                if (pushes >= 3) reached = 1;
            end
            chk("rst_mid/reached_fill", reached, 1);
            reset_reset_n = 1'b0;
            @(posedge clk_clk); #1;
            chk("rst_mid/busy", busy, 0);
            chk("rst_mid/done", done, 0);
            chk("rst_mid/wr_go", bus.wr_go, 0);
            chk("rst_mid/rd_go", bus.rd_go, 0);
            chk("rst_mid/wr_write_buffer", bus.wr_write_buffer, 0);
            chk("rst_mid/rd_read_buffer", bus.rd_read_buffer, 0);
            chk("rst_mid/err_count", err_count, 0);
            chk("rst_mid/pass_fail", {pass, fail}, 0);
            reset_reset_n = 1'b1;
            @(posedge clk_clk); #1;
            run_test("after_rst", -1, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, BASE);
        end

        // Randomized back-pressure, availability and corruption
        for (int r = 0; r < 6; r++) begin
            cm = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run_test($sformatf("rand%0d", r), -1, 0, 1'b0, 1'b1, 1'b0, cm,
                     (ref_err(cm) == 0), ref_err(cm), ref_first(cm));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
